// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS multicycle control unit.
package mips_ctrl_pkg;

  // Control FSM states; the encoding is also exported on state_o for debug.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_EXCEPT   = 4'd13
  } state_e;

  // Opcodes (IR[31:26]) understood by the controller.
  localparam logic [5:0] OP_R        = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_J        = 6'b000010;

  // SPECIAL2 function codes that are implemented (count leading zeros/ones).
  localparam logic [5:0] FN_CLZ = 6'b100000;
  localparam logic [5:0] FN_CLO = 6'b100001;

  // ALU operation classes.
  localparam logic [2:0] ALU_ARITH = 3'b000;
  localparam logic [2:0] ALU_EQ    = 3'b001;
  localparam logic [2:0] ALU_LT    = 3'b010;
  localparam logic [2:0] ALU_GT    = 3'b011;
  localparam logic [2:0] ALU_CNT   = 3'b100;
  localparam logic [2:0] ALU_ADDI  = 3'b101;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // States in which the controller is waiting on the memory handshake.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_alu_ctrl_decode.sv
// Combinational ALU control: maps the FSM state and instruction fields
// onto the alu_code / alu_funct pair the ALU consumes.
import mips_ctrl_pkg::*;

module mips_alu_ctrl_decode (
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  output logic [2:0]  alu_code_o,
  output logic [5:0]  alu_funct_o
);

  // Select the ALU operation class for the current state.
  always_comb begin
    alu_code_o  = ALU_ARITH;
    alu_funct_o = 6'b000000;
    case (state_i)
      S_FETCH, S_DECODE, S_EXEC_I, S_MEM_ADDR: begin
        // PC+4, branch target and base+offset are all plain adds.
        alu_code_o = ALU_ADDI;
      end
      S_EXEC_R: begin
        alu_funct_o = funct_i;
        if (opcode_i == OP_SPECIAL2) begin
          alu_code_o = ALU_CNT;
        end else begin
          alu_code_o = ALU_ARITH;
        end
      end
      S_BRANCH: begin
        alu_code_o = ALU_EQ;
      end
      default: begin
        alu_code_o  = ALU_ARITH;
        alu_funct_o = 6'b000000;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// write-back, drives datapath enables and mux selects, and watches the
// memory handshake for stalls that run too long.
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_result_bit0,
  input  logic        mem_ready,
  output logic [2:0]  alu_code,
  output logic [5:0]  alu_funct,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic        mem_timeout,
  output logic [3:0]  state_o
);

  // Counter must be able to hold MEM_WAIT_MAX+1, the first "exceeded" value.
  localparam int             CNT_W     = $clog2(MEM_WAIT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MEM_WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  // State, watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic; opcode/funct stay stable from DECODE to write-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_SPECIAL2: begin
            if ((funct == FN_CLZ) || (funct == FN_CLO)) state_d = S_EXEC_R;
            else                                         state_d = S_EXCEPT;
          end
          OP_ADDI, OP_ADDIU: state_d = S_EXEC_I;
          OP_LW, OP_SW:      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:    state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          default:           state_d = S_EXCEPT;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: begin
        if (opcode == OP_LW) state_d = S_MEM_RD;
        else                 state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
        else           state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEM_WR;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_EXCEPT: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Watchdog: count consecutive stalled memory cycles, flag once past the limit.
  always_comb begin
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (is_mem_state(state_q) && !mem_ready) begin
      if (wait_cnt_q != CNT_SAT) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      else                       wait_cnt_d = wait_cnt_q;
      if (wait_cnt_q >= CNT_LIMIT) mem_timeout_d = 1'b1;
      else                         mem_timeout_d = mem_timeout_q;
    end else begin
      wait_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Datapath controls decoded from the state register (Mealy only on
  // pc_write/ir_write in FETCH and pc_write in BRANCH).
  always_comb begin
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_source  = PCSRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        // rs + sign-extended immediate
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: begin
        reg_write = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        // ALU equality compare lands in bit 0; zero flag is not trustworthy here.
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        if (opcode == OP_BNE) pc_write = !alu_result_bit0;
        else                  pc_write = alu_result_bit0;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_EXCEPT: begin
        illegal_op = 1'b1;
        pc_write   = 1'b1;
        pc_source  = PCSRC_EXC;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  mips_alu_ctrl_decode u_alu_dec (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .funct_i     (funct),
    .alu_code_o  (alu_code),
    .alu_funct_o (alu_funct)
  );

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: every cycle the expected output
// vector is pushed when inputs are driven and popped at the falling edge.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int MEM_WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic alu_result_bit0 = 1'b0;
  logic mem_ready = 1'b0;
  logic [2:0] alu_code;
  logic [5:0] alu_funct;
  logic alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic pc_write, ir_write, mem_read, mem_write, iord;
  logic reg_write, reg_dst, mem_to_reg, illegal_op, mem_timeout;
  logic [3:0] state_o;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_result_bit0(alu_result_bit0), .mem_ready(mem_ready),
    .alu_code(alu_code), .alu_funct(alu_funct), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_write(pc_write),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Packed view: state, alu_code, alu_funct, src_a, src_b, pc_source, then 10 flags.
  logic [27:0] obs;
  assign obs = {state_o, alu_code, alu_funct, alu_src_a, alu_src_b, pc_source,
                pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                reg_dst, mem_to_reg, illegal_op, mem_timeout};

  int checks = 0;
  int errors = 0;
  logic exp_to = 1'b0;
  int wcnt = 0;
  logic [27:0] sb_q[$];

  // Expected outputs for one cycle, written from the control table.
  function automatic logic [27:0] exp_out(input state_e st, input logic [5:0] op,
                                          input logic [5:0] fn, input logic mr,
                                          input logic b0, input logic to);
    logic [2:0] code; logic [5:0] af; logic sa; logic [1:0] sb, ps;
    logic pw, irw, mrd, mwr, io, rw, rd, m2r, ill;
    code = 3'b000; af = 6'b000000; sa = 1'b0; sb = 2'b00; ps = 2'b00;
    pw = 1'b0; irw = 1'b0; mrd = 1'b0; mwr = 1'b0; io = 1'b0;
    rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
    case (st)
      S_FETCH:    begin code = 3'b101; sb = 2'b01; mrd = 1'b1; pw = mr; irw = mr; end
      S_DECODE:   begin code = 3'b101; sb = 2'b11; end
      S_EXEC_R:   begin sa = 1'b1; af = fn; code = (op == 6'b011100) ? 3'b100 : 3'b000; end
      S_EXEC_I,
      S_MEM_ADDR: begin code = 3'b101; sa = 1'b1; sb = 2'b10; end
      S_MEM_RD:   begin io = 1'b1; mrd = 1'b1; end
      S_MEM_WR:   begin io = 1'b1; mwr = 1'b1; end
      S_WB_R:     begin rw = 1'b1; rd = 1'b1; end
      S_WB_I:     begin rw = 1'b1; end
      S_WB_MEM:   begin rw = 1'b1; m2r = 1'b1; end
      S_BRANCH:   begin code = 3'b001; sa = 1'b1; ps = 2'b01; pw = (op == 6'b000100) ? b0 : !b0; end
      S_JUMP:     begin pw = 1'b1; ps = 2'b10; end
      S_EXCEPT:   begin ill = 1'b1; pw = 1'b1; ps = 2'b11; end
      default:    begin code = 3'b000; end
    endcase
    return {4'(st), code, af, sa, sb, ps, pw, irw, mrd, mwr, io, rw, rd, m2r, ill, to};
  endfunction

  // Expected successor state.
  function automatic state_e exp_next(input state_e st, input logic [5:0] op,
                                      input logic [5:0] fn, input logic mr);
    case (st)
      S_FETCH:  return mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == 6'b000000) return S_EXEC_R;
        if (op == 6'b011100 && (fn == 6'b100000 || fn == 6'b100001)) return S_EXEC_R;
        if (op == 6'b001000 || op == 6'b001001) return S_EXEC_I;
        if (op == 6'b100011 || op == 6'b101011) return S_MEM_ADDR;
        if (op == 6'b000100 || op == 6'b000101) return S_BRANCH;
        if (op == 6'b000010) return S_JUMP;
        return S_EXCEPT;
      end
      S_EXEC_R:   return S_WB_R;
      S_EXEC_I:   return S_WB_I;
      S_MEM_ADDR: return (op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   return mr ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   return mr ? S_FETCH : S_MEM_WR;
      default:    return S_FETCH;
    endcase
  endfunction

  task automatic test_reset();
    logic [27:0] ev;
    ev = {4'(S_IDLE), 24'd0};
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== ev) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs, ev); end
    rst_n = 1'b1;
    checks++;
    if (obs !== ev) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, ev); end
    @(posedge clk); #1;
    checks++;
    if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_to_fetch: got %0d expected %0d", state_o, S_FETCH); end
    exp_to = 1'b0; wcnt = 0;
  endtask

  // Runs one instruction from FETCH, fw fetch stalls and mw memory stalls.
  task automatic test_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic b0, input int fw, input int mw, input int exp_cycles);
    state_e st; logic mr; logic [27:0] ev; logic [3:0] prev;
    int cyc, fwl, mwl; bit done;
    st = S_FETCH; fwl = fw; mwl = mw; cyc = 0; done = 1'b0;
    opcode = op; funct = fn; alu_result_bit0 = b0;
    while (!done && cyc < 64) begin
      if (st == S_FETCH) mr = (fwl == 0);
      else if (st == S_MEM_RD || st == S_MEM_WR) mr = (mwl == 0);
      else mr = 1'($urandom_range(0, 1));
      mem_ready = mr;
      sb_q.push_back(exp_out(st, op, fn, mr, b0, exp_to));
      @(negedge clk);
      ev = sb_q.pop_front();
      prev = state_o;
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, ev);
      end
      if ((st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) && !mr) begin
        wcnt++;
        if (wcnt > MEM_WAIT_MAX) exp_to = 1'b1;
        if (st == S_FETCH) fwl--; else mwl--;
      end else begin
        wcnt = 0;
      end
      st = exp_next(st, op, fn, mr);
      cyc++;
      @(posedge clk); #1;
      if (state_o === S_FETCH && prev !== S_FETCH) done = 1'b1;
    end
    checks++;
    if (!done || cyc != exp_cycles) begin
      errors++;
      $display("FAIL %s_cycles: got %0d (returned=%0d) expected %0d", name, cyc, done, exp_cycles);
    end
  endtask

  task automatic test_watchdog();
    // 20 stalled fetch cycles: flag rises after the 16th and stays set.
    test_instr("watchdog_add", 6'b000000, 6'b100000, 1'b0, 20, 0, 24);
    checks++;
    if (mem_timeout !== 1'b1) begin errors++; $display("FAIL watchdog_set: got %b expected 1", mem_timeout); end
    test_instr("watchdog_sticky_j", 6'b000010, 6'b000000, 1'b0, 0, 0, 3);
  endtask

  task automatic test_reset_mid_write();
    opcode = 6'b101011; funct = 6'd0; mem_ready = 1'b1;
    @(posedge clk); #1; mem_ready = 1'b0;   // DECODE
    @(posedge clk); #1;                     // MEM_ADDR
    @(posedge clk); #1;                     // MEM_WR
    @(negedge clk);
    checks++;
    if (state_o !== S_MEM_WR || mem_write !== 1'b1 || mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL midwr_pre: got state %0d wr %b to %b expected %0d 1 1", state_o, mem_write, mem_timeout, S_MEM_WR);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state_o !== S_IDLE || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL midwr_async: got wr %b state %0d to %b expected 0 %0d 0", mem_write, state_o, mem_timeout, S_IDLE);
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state_o !== S_FETCH || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL midwr_restart: got state %0d wr %b expected %0d 0", state_o, mem_write, S_FETCH);
    end
    exp_to = 1'b0; wcnt = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn; int base, fw, mw; bit is_mem;
    for (int i = 0; i < 20; i++) begin
      fn = 6'b100000; is_mem = 1'b0;
      case ($urandom_range(0, 7))
        0: begin op = 6'b000000; base = 4; end
        1: begin op = 6'b011100; fn = 6'b100001; base = 4; end
        2: begin op = 6'b001001; base = 4; end
        3: begin op = 6'b100011; base = 5; is_mem = 1'b1; end
        4: begin op = 6'b101011; base = 4; is_mem = 1'b1; end
        5: begin op = 6'b000101; base = 3; end
        6: begin op = 6'b000010; base = 3; end
        default: begin op = 6'b110011; base = 3; end
      endcase
      fw = $urandom_range(0, 2);
      mw = is_mem ? $urandom_range(0, 2) : 0;
      test_instr("b2b", op, fn, 1'($urandom_range(0, 1)), fw, mw, base + fw + mw);
    end
  endtask

  initial begin
    test_reset();
    test_instr("add",        6'b000000, 6'b100000, 1'b0, 0, 0, 4);
    test_instr("clo",        6'b011100, 6'b100001, 1'b0, 0, 0, 4);
    test_instr("clz",        6'b011100, 6'b100000, 1'b1, 0, 0, 4);
    test_instr("addi",       6'b001000, 6'b000101, 1'b0, 0, 0, 4);
    test_instr("addiu",      6'b001001, 6'b111111, 1'b0, 0, 0, 4);
    test_instr("lw",         6'b100011, 6'b000000, 1'b0, 0, 0, 5);
    test_instr("lw_wait2",   6'b100011, 6'b000000, 1'b0, 0, 2, 7);
    test_instr("sw_wait1",   6'b101011, 6'b000000, 1'b0, 0, 1, 5);
    test_instr("beq_taken",  6'b000100, 6'b000000, 1'b1, 0, 0, 3);
    test_instr("beq_not",    6'b000100, 6'b000000, 1'b0, 0, 0, 3);
    test_instr("bne_equal",  6'b000101, 6'b000000, 1'b1, 0, 0, 3);
    test_instr("bne_taken",  6'b000101, 6'b000000, 1'b0, 0, 0, 3);
    test_instr("jump",       6'b000010, 6'b000000, 1'b0, 0, 0, 3);
    test_instr("illegal",    6'b111111, 6'b000000, 1'b0, 0, 0, 3);
    test_instr("spec2_mul",  6'b011100, 6'b000010, 1'b0, 0, 0, 3);
    test_instr("fetch_wait", 6'b000000, 6'b100010, 1'b0, 2, 0, 6);
    test_watchdog();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM that sequences instruction fetch, decode, execute, memory and write-back for the MIPS datapath. It produces the `alu_code`/`alu_funct` pair the ALU consumes, plus all datapath enables and mux selects. It consumes the ALU's bit-0 result for branch resolution. It handshakes with instruction/data memory through a single ready signal.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: watchdog limit on consecutive `mem_ready`-low cycles; exceeding it raises `mem_timeout`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `funct` input 6: IR[5:0].
- `alu_result_bit0` input 1: ALU Result[0]; used for branch compare (equals code 001).
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `alu_code` output 3: ALU operation class.
- `alu_funct` output 6: function code to the ALU.
- `alu_src_a` output 1: 0 = PC, 1 = reg A.
- `alu_src_b` output 2: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- `pc_source` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector 0x80.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `iord`, `reg_write`, `reg_dst`, `mem_to_reg` output 1 each: standard datapath controls.
- `illegal_op` output 1: one-cycle pulse on an undecodable opcode.
- `mem_timeout` output 1: sticky until reset.
- `state_o` output 4: current state encoding, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, EXCEPT.
- Reset puts the FSM in IDLE. All outputs are 0 in IDLE, including `alu_code` = 000 and `alu_funct` = 000000. IDLE goes to FETCH unconditionally.
- **FETCH:** `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_code`=101, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy).
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- **DECODE:** `alu_code`=101, `alu_src_a`=0, `alu_src_b`=11 (branch target into ALUOut). Dispatch on opcode:
  - 000000 (R) → EXEC_R.
  - 011100 with funct 100000 or 100001 (CLZ/CLO) → EXEC_R.
  - 001000 / 001001 (addi/addiu) → EXEC_I.
  - 100011 (lw) / 101011 (sw) → MEM_ADDR.
  - 000100 (beq) / 000101 (bne) → BRANCH.
  - 000010 (j) → JUMP.
  - Anything else → EXCEPT.
- **EXEC_R:** `alu_src_a`=1, `alu_src_b`=00, `alu_funct`=funct.
  - `alu_code`=000 for R-type, 100 for SPECIAL2.
  - Next state WB_R.
- **EXEC_I:** `alu_code`=101, `alu_src_b`=10. Next state WB_I.
- **MEM_ADDR:** same ALU setup as EXEC_I. Next state MEM_RD (lw) or MEM_WR (sw).
- **MEM_RD / MEM_WR:** `iord`=1 and `mem_read` or `mem_write`=1, held until `mem_ready`. Then MEM_RD → WB_MEM and MEM_WR → FETCH.
- **Write-back states:**
  - WB_R: `reg_write`=1, `reg_dst`=1.
  - WB_I: `reg_write`=1, `reg_dst`=0.
  - WB_MEM: `reg_write`=1, `mem_to_reg`=1.
  - All three go to FETCH.
- **BRANCH:** `alu_code`=001, `alu_src_a`=1, `alu_src_b`=00, `pc_source`=01.
  - `pc_write` = `alu_result_bit0` for beq, `!alu_result_bit0` for bne.
  - `zeroFlag` is never used (it is valid only for signed add/sub).
  - Next state FETCH.
- **JUMP:** `pc_write`=1, `pc_source`=10. Next state FETCH.
- **EXCEPT:** `illegal_op`=1, `pc_write`=1, `pc_source`=11. Next state FETCH.
- **Watchdog:** counts consecutive FETCH/MEM_RD/MEM_WR cycles with `mem_ready`=0. When the count exceeds `MEM_WAIT_MAX`, `mem_timeout` sets. The FSM keeps waiting; it does not abort.

## Timing
- `state_o` is registered; outputs decode from the state register. The only Mealy terms are `ir_write`/`pc_write` in FETCH and `pc_write` in BRANCH.
- Cycle counts with zero wait states:
  - R-type, CLO/CLZ, addi, sw: 4.
  - lw: 5.
  - beq, bne, j, illegal: 3.
- Each memory wait cycle adds exactly one cycle.
- `rst_n` low mid-instruction clears the state to IDLE and `mem_timeout` to 0 immediately (asynchronous). No partial write is issued after reset release.
- `mem_ready` high outside FETCH/MEM_RD/MEM_WR is ignored.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit);
  - opcode constants (R, SPECIAL2, ADDI, ADDIU, LW, SW, BEQ, BNE, J);
  - ALU code constants (ARITH=000, EQ=001, LT=010, GT=011, CNT=100, ADDI=101);
  - `alu_src_b` and `pc_source` encodings.
- Sub-module `mips_alu_ctrl_decode` (combinational): (state, opcode, funct) → `alu_code`, `alu_funct`.

## Test plan
- **Reset then add:** reset, IR = 0x00851020 (add), `mem_ready`=1 → states IDLE, FETCH, DECODE, EXEC_R, WB_R.
  - In EXEC_R: `alu_code`=000, `alu_funct`=100000.
  - In WB_R: `reg_write`=1, `reg_dst`=1.
- **lw with 2 wait states:** opcode 100011, `mem_ready` low for 2 cycles in MEM_RD → instruction takes 7 cycles; `mem_to_reg`=1 in WB_MEM.
- **beq:** `alu_result_bit0`=1 → `pc_write`=1 with `pc_source`=01. Same with bne → `pc_write`=0.
- **CLO:** opcode 011100, funct 100001 → `alu_code`=100, `alu_funct`=100001 in EXEC_R.
- **Illegal opcode 111111:** `illegal_op` pulses exactly 1 cycle with `pc_source`=11; the FSM returns to FETCH.
- **Reset and watchdog:**
  - `rst_n` asserted during MEM_WR → `mem_write` drops to 0 the same cycle; state_o = IDLE.
  - 16 cycles with `mem_ready`=0 → `mem_timeout`=1 and it stays set.
